// File: rtl/countdown_digit_renderer.sv
// ============================================================================
// countdown_digit_renderer : per-second countdown digit and sprite pixel stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module countdown_digit_renderer #(
   parameter int POS_X          = 304,
   parameter int POS_Y          = 228,
   parameter int SPR_W          = 32,
   parameter int SPR_H          = 24,
   parameter int START_VAL      = 5,
   parameter int FRAMES_PER_SEC = 60,
   parameter int KEY_COLOR      = 391
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic       start,
   input  logic       pause,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic [9:0] spr_rgb,
   output logic [2:0] digit_sel,
   output logic [4:0] spr_row,
   output logic [4:0] spr_col,
   output logic [9:0] pix_rgb,
   output logic       pix_valid,
   output logic       running,
   output logic       expired
);

   localparam int         c_cnt_w   = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(FRAMES_PER_SEC - 1);
   localparam logic [2:0] c_start   = 3'(START_VAL);
   localparam logic [9:0] c_x_lo    = 10'(POS_X);
   localparam logic [9:0] c_x_hi    = 10'(POS_X + SPR_W - 1);
   localparam logic [9:0] c_y_lo    = 10'(POS_Y);
   localparam logic [9:0] c_y_hi    = 10'(POS_Y + SPR_H - 1);
   localparam logic [9:0] c_key     = 10'(KEY_COLOR);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_EXPIRE = 2'd2
   } state_t;

   logic [1:0]         r_rst_sync;
   logic               w_rst_n;
   state_t             r_state;
   logic [2:0]         r_digit;
   logic [c_cnt_w-1:0] r_frame_cnt;
   logic               r_frame_clk_d;
   logic [9:0]         r_pix_rgb;
   logic               r_pix_valid;
   logic               r_running;
   logic               r_expired;
   logic               w_frame_tick;
   logic               w_in_box;

   // Reset asserts immediately but releases only after two clean Clk edges.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         r_rst_sync <= 2'b00;
      else
         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n      = r_rst_sync[1];
   assign w_frame_tick = frame_clk & ~r_frame_clk_d;
   assign w_in_box     = (DrawX >= c_x_lo) && (DrawX <= c_x_hi) &&
                         (DrawY >= c_y_lo) && (DrawY <= c_y_hi);

   assign digit_sel = r_digit;
   assign spr_col   = w_in_box ? 5'(DrawX - c_x_lo) : 5'd0;
   assign spr_row   = w_in_box ? 5'(DrawY - c_y_lo) : 5'd0;
   assign pix_rgb   = r_pix_rgb;
   assign pix_valid = r_pix_valid;
   assign running   = r_running;
   assign expired   = r_expired;

   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state       <= S_IDLE;
         r_digit       <= c_start;
         r_frame_cnt   <= '0;
         r_frame_clk_d <= 1'b0;
         r_pix_rgb     <= '0;
         r_pix_valid   <= 1'b0;
         r_running     <= 1'b0;
         r_expired     <= 1'b0;
      end else begin
         r_frame_clk_d <= frame_clk;
         r_pix_rgb     <= w_in_box ? spr_rgb : 10'd0;
         r_pix_valid   <= w_in_box & r_running & (spr_rgb != c_key);

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_RUN;
                  r_digit     <= c_start;
                  r_frame_cnt <= '0;
                  r_running   <= 1'b1;
               end
            end
            S_RUN: begin
               // A restart takes priority over a tick landing in the same cycle.
               if (start) begin
                  r_digit     <= c_start;
                  r_frame_cnt <= '0;
               end else if (w_frame_tick && !pause) begin
                  if (r_frame_cnt == c_last_cnt) begin
                     r_frame_cnt <= '0;
                     if (r_digit != 3'd0) begin
                        r_digit <= r_digit - 3'd1;
                     end else begin
                        r_state   <= S_EXPIRE;
                        r_running <= 1'b0;
                        r_expired <= 1'b1;
                     end
                  end else begin
                     r_frame_cnt <= r_frame_cnt + 1'b1;
                  end
               end
            end
            S_EXPIRE: begin
               r_expired <= 1'b0;
               if (start) begin
                  r_state     <= S_RUN;
                  r_digit     <= c_start;
                  r_frame_cnt <= '0;
                  r_running   <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_running <= 1'b0;
               r_expired <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
